rldramii_dmaster_st_arbiter: RTL and testbench

- Packet-aware round-robin arbiter that shares the single 8-bit Avalon-ST byte stream of the RLDRAMII debug master between NUM_REQ upstream requesters.
- Grant is locked from sop to eop. Each requester is back-pressured individually.
- The output is one registered pipeline stage (ready latency 0), placed ahead of the dmaster timing adapter.
- Includes sticky protocol and stall error flags for debug.

---
 rtl/rldramii_dmaster_st_arbiter.sv | 129 ++++++++++++
 tb/tb_rldramii_dmaster_st_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rldramii_dmaster_st_arbiter.sv
// Packet-aware round-robin arbiter that shares the RLDRAMII debug-master byte stream.
// The grant is locked from sop to eop, the output is one registered stage, and sticky debug flags report framing and stall errors.
module rldramii_dmaster_st_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_W       = 8,
  parameter int STALL_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        in_valid,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  input  logic [NUM_REQ-1:0]        in_sop,
  input  logic [NUM_REQ-1:0]        in_eop,
  output logic [NUM_REQ-1:0]        in_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_sop,
  output logic                      out_eop,
  input  logic                      out_ready,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      err_clr,
  output logic                      proto_err,
  output logic                      stall_err
);
  localparam int          IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] STALL_MAX = 16'(STALL_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      gidx;
  logic [IW-1:0]      win_idx;
  logic               win_found;
  logic               first_pending;
  logic [15:0]        stall_cnt;
  logic [NUM_REQ-1:0] cand;
  logic               sel_valid, sel_sop, sel_eop;
  logic [DATA_W-1:0]  sel_data;
  logic               out_free, accept, stall_tick, stall_set, proto_set;

  assign cand      = in_valid & in_sop;
  assign out_free  = out_ready | ~out_valid;
  // grant is all-zero outside BUSY, so this also keeps everyone unready while idle
  assign in_ready  = grant & {NUM_REQ{out_free}};
  assign sel_valid = in_valid[gidx];
  assign sel_sop   = in_sop[gidx];
  assign sel_eop   = in_eop[gidx];
  assign sel_data  = in_data[gidx*DATA_W +: DATA_W];
  assign accept    = (state == BUSY) & sel_valid & out_free;

  assign stall_tick = (state == BUSY) & ~first_pending & ~sel_valid & (stall_cnt != STALL_MAX);
  assign stall_set  = stall_tick & (stall_cnt == STALL_MAX - 16'd1);
  assign proto_set  = ((state == IDLE) & |(in_valid & ~in_sop)) |
                      (accept & sel_sop & ~first_pending);

  // Round-robin search that starts just above the previous winner
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && cand[(int'(last_grant) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(last_grant) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = BUSY;
      BUSY:    if (accept && sel_eop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      grant         <= '0;
      gidx          <= '0;
      last_grant    <= IW'(NUM_REQ - 1);
      first_pending <= 1'b0;
      stall_cnt     <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_sop       <= 1'b0;
      out_eop       <= 1'b0;
      proto_err     <= 1'b0;
      stall_err     <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && win_found) begin
        grant         <= NUM_REQ'(1) << win_idx;
        gidx          <= win_idx;
        first_pending <= 1'b1;
        stall_cnt     <= '0;
      end else if (accept) begin
        first_pending <= 1'b0;
        stall_cnt     <= '0;
        if (sel_eop) begin
          grant      <= '0;
          last_grant <= gidx;
        end
      end else if (stall_tick) begin
        stall_cnt <= stall_cnt + 16'd1;
      end

      // Output data is held until consumed; only valid drops when drained
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sop   <= sel_sop;
        out_eop   <= sel_eop;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (proto_set)    proto_err <= 1'b1;
      else if (err_clr) proto_err <= 1'b0;

      if (stall_set)    stall_err <= 1'b1;
      else if (err_clr) stall_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rldramii_dmaster_st_arbiter.sv
// Directed testbench for rldramii_dmaster_st_arbiter.
// Each source queue holds {sop,eop,data} beats, and the output beats are logged in order for comparison.
module tb_rldramii_dmaster_st_arbiter;
  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 8;
  localparam int STALL   = 4;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic [NUM_REQ-1:0]        in_valid = '0;
  logic [NUM_REQ*DATA_W-1:0] in_data = '0;
  logic [NUM_REQ-1:0]        in_sop = '0;
  logic [NUM_REQ-1:0]        in_eop = '0;
  logic [NUM_REQ-1:0]        in_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_sop;
  logic                      out_eop;
  logic                      out_ready = 1'b1;
  logic [NUM_REQ-1:0]        grant;
  logic                      err_clr = 1'b0;
  logic                      proto_err;
  logic                      stall_err;

  logic [9:0]         srcQ[NUM_REQ][$];
  logic [NUM_REQ-1:0] holdValid = '0;
  logic [9:0]         obsQ[$];
  int                 obsCyc[$];
  logic [NUM_REQ-1:0] grantLog[$];
  int                 cyc = 0;
  int                 testsRun = 0;
  int                 testsFailed = 0;

  always #5 clk = ~clk;

  rldramii_dmaster_st_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .STALL_CYCLES(STALL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_ready(out_ready), .grant(grant),
    .err_clr(err_clr), .proto_err(proto_err), .stall_err(stall_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    logic [9:0] b;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (srcQ[i].size() > 0 && !holdValid[i]) begin
        b = srcQ[i][0];
        in_valid[i] = 1'b1;
        in_sop[i]   = b[9];
        in_eop[i]   = b[8];
        in_data[i*DATA_W +: DATA_W] = b[7:0];
      end else begin
        in_valid[i] = 1'b0;
        in_sop[i]   = 1'b0;
        in_eop[i]   = 1'b0;
        in_data[i*DATA_W +: DATA_W] = '0;
      end
    end
  endtask

  task automatic tick();
    logic [NUM_REQ-1:0] hs;
    hs = in_valid & in_ready;
    if (out_valid && out_ready) begin
      obsQ.push_back({out_sop, out_eop, out_data});
      obsCyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NUM_REQ; i++)
      if (hs[i]) void'(srcQ[i].pop_front());
    applyStimulus();
    #1;
  endtask

  task automatic doReset();
    reset_n   = 1'b0;
    err_clr   = 1'b0;
    out_ready = 1'b1;
    holdValid = '0;
    for (int i = 0; i < NUM_REQ; i++) srcQ[i].delete();
    applyStimulus();
    tick();
    tick();
    reset_n = 1'b1;
    obsQ.delete();
    obsCyc.delete();
    grantLog.delete();
    cyc = 0;
  endtask

  task automatic runUntil(input int n, input int budget, input string tag);
    int c = 0;
    while (obsQ.size() < n && c < budget) begin
      tick();
      c++;
    end
    checkOutput(tag, obsQ.size(), n);
  endtask

  function automatic logic [31:0] obsAt(input int k);
    return (k < obsQ.size()) ? 32'(obsQ[k]) : 32'hFFFF_FFFF;
  endfunction

  // Expected output order for both requesters packets (r0 B*, r1 C*)
  logic [9:0] exp2[8] = '{10'h2B0, 10'h1B1, 10'h2C0, 10'h1C1, 10'h2B2, 10'h1B3, 10'h2C2, 10'h1C3};
  int         cyc2[8] = '{2, 3, 5, 6, 8, 9, 11, 12};
  logic [1:0] gnt2[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [9:0] exp3[4] = '{10'h2D0, 10'h0D1, 10'h0D2, 10'h1D3};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [NUM_REQ-1:0] prevG;
    int c;

    // Reset state
    doReset();
    checkOutput("rst out_valid", out_valid, 0);
    checkOutput("rst out_data", out_data, 0);
    checkOutput("rst out_sop", out_sop, 0);
    checkOutput("rst out_eop", out_eop, 0);
    checkOutput("rst grant", grant, 0);
    checkOutput("rst in_ready", in_ready, 0);
    checkOutput("rst proto_err", proto_err, 0);
    checkOutput("rst stall_err", stall_err, 0);

    // Single 3-byte packet from requester 0
    srcQ[0].push_back(10'h2A1); srcQ[0].push_back(10'h0A2); srcQ[0].push_back(10'h1A3);
    applyStimulus(); #1;
    checkOutput("t1 c0 grant", grant, 0);
    checkOutput("t1 c0 in_ready", in_ready, 0);
    tick();
    checkOutput("t1 c1 grant", grant, 2'b01);
    checkOutput("t1 c1 out_valid", out_valid, 0);
    checkOutput("t1 c1 in_ready", in_ready, 2'b01);
    tick();
    checkOutput("t1 c2 beat", {out_valid, out_sop, out_eop, out_data}, {3'b110, 8'hA1});
    tick();
    checkOutput("t1 c3 beat", {out_valid, out_sop, out_eop, out_data}, {3'b100, 8'hA2});
    tick();
    checkOutput("t1 c4 beat", {out_valid, out_sop, out_eop, out_data}, {3'b101, 8'hA3});
    checkOutput("t1 c4 grant", grant, 0);
    tick();
    checkOutput("t1 c5 out_valid", out_valid, 0);
    checkOutput("t1 proto_err", proto_err, 0);

    // Both requesters contend: alternating grants with one bubble between packets
    doReset();
    srcQ[0].push_back(10'h2B0); srcQ[0].push_back(10'h1B1);
    srcQ[0].push_back(10'h2B2); srcQ[0].push_back(10'h1B3);
    srcQ[1].push_back(10'h2C0); srcQ[1].push_back(10'h1C1);
    srcQ[1].push_back(10'h2C2); srcQ[1].push_back(10'h1C3);
    applyStimulus(); #1;
    c = 0;
    while (obsQ.size() < 8 && c < 60) begin
      prevG = grant;
      tick();
      if (prevG == 0 && grant != 0) grantLog.push_back(grant);
      c++;
    end
    checkOutput("t2 beats", obsQ.size(), 8);
    checkOutput("t2 grants", grantLog.size(), 4);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("t2 beat%0d", k), obsAt(k), 32'(exp2[k]));
      checkOutput($sformatf("t2 cyc%0d", k), (k < obsCyc.size()) ? obsCyc[k] : -1, cyc2[k]);
    end
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("t2 grant%0d", k), (k < grantLog.size()) ? 32'(grantLog[k]) : 32'hFF, 32'(gnt2[k]));

    // Downstream back-pressure mid-packet
    doReset();
    srcQ[0].push_back(10'h2D0); srcQ[0].push_back(10'h0D1);
    srcQ[0].push_back(10'h0D2); srcQ[0].push_back(10'h1D3);
    applyStimulus(); #1;
    tick(); tick();
    out_ready = 1'b0; #1;
    checkOutput("t3 stall in_ready", in_ready, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("t3 hold%0d", k), {out_valid, out_sop, out_data}, {2'b11, 8'hD0});
      checkOutput($sformatf("t3 in_ready%0d", k), in_ready, 0);
    end
    out_ready = 1'b1; #1;
    runUntil(4, 30, "t3 beats");
    tick(); tick();
    checkOutput("t3 no extra", obsQ.size(), 4);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("t3 beat%0d", k), obsAt(k), 32'(exp3[k]));

    // Framing errors: valid without sop while idle, clear, set-wins, mid-packet sop
    doReset();
    srcQ[1].push_back(10'h055);
    applyStimulus(); #1;
    checkOutput("t4 in_ready idle", in_ready, 0);
    tick();
    checkOutput("t4 proto set", proto_err, 1);
    checkOutput("t4 in_ready", in_ready, 0);
    checkOutput("t4 grant", grant, 0);
    err_clr = 1'b1;
    tick();
    checkOutput("t4 set wins", proto_err, 1);
    srcQ[1].delete();
    applyStimulus(); #1;
    tick();
    err_clr = 1'b0;
    checkOutput("t4 cleared", proto_err, 0);
    srcQ[0].push_back(10'h2E0); srcQ[0].push_back(10'h3E1);
    applyStimulus(); #1;
    runUntil(2, 20, "t4 beats");
    checkOutput("t4 sop beat passes", obsAt(1), 32'h3E1);
    checkOutput("t4 busy sop proto", proto_err, 1);

    // Stall detection with STALL_CYCLES=4
    doReset();
    srcQ[0].push_back(10'h2F0); srcQ[0].push_back(10'h0F1); srcQ[0].push_back(10'h1F2);
    applyStimulus(); #1;
    tick(); tick();
    holdValid[0] = 1'b1;
    applyStimulus(); #1;
    tick(); tick(); tick();
    checkOutput("t5 no stall yet", stall_err, 0);
    tick();
    checkOutput("t5 stall set", stall_err, 1);
    checkOutput("t5 grant held", grant, 2'b01);
    holdValid[0] = 1'b0;
    applyStimulus(); #1;
    runUntil(3, 20, "t5 beats");
    checkOutput("t5 beat1", obsAt(1), 32'h0F1);
    checkOutput("t5 beat2", obsAt(2), 32'h1F2);
    tick();
    checkOutput("t5 grant released", grant, 0);
    checkOutput("t5 sticky", stall_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("t5 cleared", stall_err, 0);

    // Reset mid-packet restores requester 0 priority
    doReset();
    srcQ[0].push_back(10'h311);
    srcQ[0].push_back(10'h221); srcQ[0].push_back(10'h022); srcQ[0].push_back(10'h123);
    applyStimulus(); #1;
    tick(); tick(); tick(); tick();
    checkOutput("t6 pre data", {out_valid, out_data}, {1'b1, 8'h21});
    reset_n = 1'b0;
    srcQ[0].delete();
    applyStimulus(); #1;
    tick();
    checkOutput("t6 out_valid", out_valid, 0);
    checkOutput("t6 out_data", out_data, 0);
    checkOutput("t6 out_sop", out_sop, 0);
    checkOutput("t6 grant", grant, 0);
    checkOutput("t6 in_ready", in_ready, 0);
    reset_n = 1'b1;
    obsQ.delete();
    srcQ[0].push_back(10'h331);
    srcQ[1].push_back(10'h341);
    applyStimulus(); #1;
    tick();
    checkOutput("t6 priority", grant, 2'b01);
    runUntil(2, 20, "t6 beats");
    checkOutput("t6 first", obsAt(0), 32'h331);
    checkOutput("t6 second", obsAt(1), 32'h341);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
